// File: rtl/booth_pp_accum.sv
// Accumulates the 33 radix-4 Booth partial products of a 64x64 multiply into a
// 128-bit product. Define BOOTH_PP_ACCUM_CHK_EN to add i_pp_last framing checks.
module booth_pp_accum #(
    parameter int PP_W   = 66,
    parameter int PP_N   = 33,
    parameter int PROD_W = 128
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_pp_valid,
    output logic              o_pp_ready,
    input  logic [PP_W-1:0]   i_pp,
    input  logic              i_pp_last,
    output logic              o_prod_valid,
    input  logic              i_prod_ready,
    output logic [PROD_W-1:0] o_prod,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [5:0]        k;
    logic [PROD_W-1:0] acc;
    logic              accept;
    logic              last_beat;
    logic [PROD_W-1:0] pp_ext;
    logic [PROD_W-1:0] pp_shifted;
    logic [PROD_W-1:0] acc_sum;

    assign accept    = i_pp_valid & o_pp_ready;
    assign last_beat = (k == 6'(PP_N - 1));

    // Beat k carries weight 4^k; shifting the sign-extended value by 2k and
    // truncating to 128 bits gives the exact product bits for any signedness.
    assign pp_ext     = {{(PROD_W - PP_W){i_pp[PP_W-1]}}, i_pp};
    assign pp_shifted = pp_ext << {k, 1'b0};
    assign acc_sum    = ((k == 6'd0) ? '0 : acc) + pp_shifted;

    // NOTE: state_nxt is given its default before the case so no path leaves it
    // unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = last_beat ? DONE : ACC;
            ACC:  if (accept && last_beat) state_nxt = DONE;
            DONE: if (i_prod_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_clr) state_nxt = IDLE;
    end

    // Handshake outputs are registered from the next state, so neither
    // i_pp_valid nor i_prod_ready reaches o_pp_ready combinationally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            k            <= 6'd0;
            acc          <= '0;
            o_pp_ready   <= 1'b1;
            o_prod_valid <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_pp_ready   <= (state_nxt != DONE);
            o_prod_valid <= (state_nxt == DONE);
            o_busy       <= (state_nxt != IDLE);
            if (state_nxt == IDLE) begin
                k <= 6'd0;
            end else if (accept) begin
                k <= k + 6'd1;
            end
            if (accept && !i_clr) begin
                acc <= acc_sum;
            end
        end
    end

    assign o_prod = acc;

`ifdef BOOTH_PP_ACCUM_CHK_EN
    logic err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err <= 1'b0;
        end else if (i_clr) begin
            err <= 1'b0;
        end else if (accept && (i_pp_last != last_beat)) begin
            err <= 1'b1;
        end
    end

    assign o_err = err;
`else
    logic unused_pp_last;

    assign unused_pp_last = i_pp_last;
    assign o_err          = 1'b0;
`endif

endmodule
